// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FAULT = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_code_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/instr_fetch_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives a registered program ROM, handles stall,
// redirect and address faults, and keeps transfer/stall performance counters.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_BYTES = 65536
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] ROM_ADDR,
  input  logic [31:0] ROM_DATA,
  output logic [31:0] INSTR_OUT,
  output logic [31:0] PC_OUT,
  output logic [31:0] PC_PLUS4_OUT,
  output logic        VALID_OUT,
  output logic [1:0]  FAULT_CODE,
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] STALL_COUNT
);

  fetch_state_e state_q;
  fault_code_e  fault_q;
  logic [31:0]  pc_q;
  logic         valid_q;

  logic [32:0]  sel_addr;
  logic         misalign;
  logic         out_of_range;
  logic         fetch_en;
  logic         stall_en;

  // Carry bit kept so a sequential step wrapping past 2^32 counts as out of range.
  always_comb begin
    sel_addr = {1'b0, pc_q} + {1'b0, PC_STEP};
    if (REDIRECT) begin
      sel_addr = {1'b0, REDIRECT_PC};
    end else if (STALL) begin
      sel_addr = {1'b0, pc_q};
    end
    misalign     = REDIRECT && (REDIRECT_PC[1:0] != 2'b00);
    out_of_range = sel_addr >= 33'(ROM_BYTES);

    ROM_ADDR = pc_q;
    case (state_q)
      ST_BOOT: ROM_ADDR = RESET_PC;
      ST_RUN:  ROM_ADDR = (misalign || out_of_range) ? pc_q : sel_addr[31:0];
      default: ROM_ADDR = pc_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      fault_q <= FAULT_NONE;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_RUN;
          pc_q    <= RESET_PC;
          valid_q <= 1'b1;
        end
        ST_RUN: begin
          if (misalign) begin
            state_q <= ST_FAULT;
            fault_q <= FAULT_MISALIGN;
            valid_q <= 1'b0;
          end else if (out_of_range) begin
            state_q <= ST_FAULT;
            fault_q <= FAULT_RANGE;
            valid_q <= 1'b0;
          end else begin
            pc_q <= ROM_ADDR;
          end
        end
        ST_FAULT: begin
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= ST_BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // valid_q is high exactly while in RUN, so it doubles as the RUN qualifier.
  assign fetch_en = valid_q && !STALL;
  assign stall_en = valid_q && STALL;

  sat_counter #(.WIDTH(32)) u_fetch_cnt (
    .clk_i   (CLK),
    .rst_i   (RST),
    .en_i    (fetch_en),
    .count_o (FETCH_COUNT)
  );

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk_i   (CLK),
    .rst_i   (RST),
    .en_i    (stall_en),
    .count_o (STALL_COUNT)
  );

  assign INSTR_OUT    = ROM_DATA;
  assign PC_OUT       = pc_q;
  assign PC_PLUS4_OUT = pc_q + PC_STEP;
  assign VALID_OUT    = valid_q;
  assign FAULT_CODE   = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected PCs, a monitor
// checks every valid output cycle against a registered ROM model.
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        STALL = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic [31:0] ROM_ADDR;
  logic [31:0] ROM_DATA;
  logic [31:0] INSTR_OUT;
  logic [31:0] PC_OUT;
  logic [31:0] PC_PLUS4_OUT;
  logic        VALID_OUT;
  logic [1:0]  FAULT_CODE;
  logic [31:0] FETCH_COUNT;
  logic [31:0] STALL_COUNT;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  instr_fetch #(.RESET_PC(32'h0000_0000), .ROM_BYTES(65536)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .STALL        (STALL),
    .REDIRECT     (REDIRECT),
    .REDIRECT_PC  (REDIRECT_PC),
    .ROM_ADDR     (ROM_ADDR),
    .ROM_DATA     (ROM_DATA),
    .INSTR_OUT    (INSTR_OUT),
    .PC_OUT       (PC_OUT),
    .PC_PLUS4_OUT (PC_PLUS4_OUT),
    .VALID_OUT    (VALID_OUT),
    .FAULT_CODE   (FAULT_CODE),
    .FETCH_COUNT  (FETCH_COUNT),
    .STALL_COUNT  (STALL_COUNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {2'b00, a[31:2]};
  endfunction

  always @(posedge CLK) ROM_DATA <= rom_word(ROM_ADDR);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus starting at a negedge; ev/epc is the PC expected
  // on the outputs after the coming rising edge.
  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] epc);
    STALL       = st;
    REDIRECT    = rd;
    REDIRECT_PC = rpc;
    if (ev) exp_q.push_back(epc);
    @(negedge CLK);
  endtask

  task automatic reset_pulse();
    #2 RST = 1'b1;
    #1;
    chk("rst_valid", 32'(VALID_OUT), 32'd0);
    chk("rst_fault", 32'(FAULT_CODE), 32'd0);
    chk("rst_pc", PC_OUT, 32'h0);
    chk("rst_fetch_cnt", FETCH_COUNT, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(posedge CLK);
      #1;
      if (VALID_OUT === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got pc %h expected no valid output", PC_OUT);
        end else begin
          e = exp_q.pop_front();
          chk("mon_pc", PC_OUT, e);
          chk("mon_instr", INSTR_OUT, rom_word(e));
          chk("mon_pc4", PC_PLUS4_OUT, e + 32'd4);
        end
      end
    end
  end

  initial begin : stimulus
    repeat (2) @(negedge CLK);
    chk("reset_valid", 32'(VALID_OUT), 32'd0);
    chk("reset_fault", 32'(FAULT_CODE), 32'd0);
    chk("reset_pc", PC_OUT, 32'h0);
    chk("reset_fetch_cnt", FETCH_COUNT, 32'd0);
    chk("reset_stall_cnt", STALL_COUNT, 32'd0);
    chk("reset_rom_addr", ROM_ADDR, 32'h0);

    RST = 1'b0;
    chk("boot_valid", 32'(VALID_OUT), 32'd0);
    drive(0, 0, 32'h0, 1, 32'h0);
    drive(0, 0, 32'h0, 1, 32'h4);
    drive(0, 0, 32'h0, 1, 32'h8);

    repeat (3) drive(1, 0, 32'h0, 1, 32'h8);
    chk("stall_cnt_3", STALL_COUNT, 32'd3);
    drive(0, 0, 32'h0, 1, 32'hC);
    chk("fetch_cnt_3", FETCH_COUNT, 32'd3);

    drive(1, 1, 32'h100, 1, 32'h100);
    chk("redirect_valid", 32'(VALID_OUT), 32'd1);
    chk("redirect_instr", INSTR_OUT, 32'hC0DE_0040);
    chk("stall_cnt_4", STALL_COUNT, 32'd4);
    drive(0, 0, 32'h0, 1, 32'h104);
    chk("fetch_cnt_4", FETCH_COUNT, 32'd4);

    force dut.u_fetch_cnt.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_fetch_cnt.count_q;
    chk("preload", FETCH_COUNT, 32'hFFFF_FFFE);
    drive(0, 0, 32'h0, 1, 32'h108);
    chk("sat_first", FETCH_COUNT, 32'hFFFF_FFFF);
    drive(0, 0, 32'h0, 1, 32'h10C);
    drive(0, 0, 32'h0, 1, 32'h110);
    chk("sat_hold", FETCH_COUNT, 32'hFFFF_FFFF);

    drive(0, 1, 32'h102, 0, 32'h0);
    chk("misalign_code", 32'(FAULT_CODE), 32'd1);
    chk("misalign_valid", 32'(VALID_OUT), 32'd0);
    chk("misalign_pc", PC_OUT, 32'h110);
    chk("fault_rom_addr", ROM_ADDR, 32'h110);
    drive(1, 1, 32'h200, 0, 32'h0);
    drive(0, 0, 32'h0, 0, 32'h0);
    chk("fault_frozen_pc", PC_OUT, 32'h110);
    chk("fault_frozen_code", 32'(FAULT_CODE), 32'd1);
    chk("fault_frozen_stall", STALL_COUNT, 32'd4);
    chk("fault_frozen_fetch", FETCH_COUNT, 32'hFFFF_FFFF);

    reset_pulse();
    drive(0, 0, 32'h0, 1, 32'h0);
    drive(0, 0, 32'h0, 1, 32'h4);
    drive(0, 1, 32'h1_0000, 0, 32'h0);
    chk("range_code", 32'(FAULT_CODE), 32'd2);
    chk("range_pc", PC_OUT, 32'h4);
    chk("range_valid", 32'(VALID_OUT), 32'd0);

    reset_pulse();
    drive(0, 0, 32'h0, 1, 32'h0);
    drive(0, 1, 32'h1_0002, 0, 32'h0);
    chk("both_fault_code", 32'(FAULT_CODE), 32'd1);

    reset_pulse();
    drive(0, 0, 32'h0, 1, 32'h0);
    drive(0, 1, 32'hFFF8, 1, 32'hFFF8);
    drive(0, 0, 32'h0, 1, 32'hFFFC);
    drive(0, 0, 32'h0, 0, 32'h0);
    chk("seq_range_code", 32'(FAULT_CODE), 32'd2);
    chk("seq_range_pc", PC_OUT, 32'hFFFC);
    chk("seq_range_valid", 32'(VALID_OUT), 32'd0);

    reset_pulse();
    drive(0, 0, 32'h0, 1, 32'h0);
    drive(1, 0, 32'h0, 1, 32'h0);
    reset_pulse();
    drive(0, 0, 32'h0, 1, 32'h0);
    drive(0, 0, 32'h0, 1, 32'h4);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
